bus_host_arbiter: RTL
=====================

Name: bus_host_arbiter

Overview:
- Round-robin arbiter that lets NrHosts bus hosts (core data port, debug SBA host, future DMA) share one device-side bus port.
- Uses the same req/gnt/rvalid protocol as the system bus.
- Tracks outstanding transactions in an ID FIFO, so each response returns to the host that issued the request.
- Sits between the hosts and the address decoder/device side of the bus.

Parameters:
- NrHosts, 2, number of requesting hosts (2..8).
- AddrWidth, 32, address width.
- DataWidth, 32, data width (multiple of 8).
- MaxOutstanding, 4, depth of the outstanding-ID FIFO (power of two, at least 2).
- IdW (localparam), clog2(NrHosts), width of a host ID.

Ports:
- clk_sys_i  in  1  system clock
- rst_sys_ni  in  1  reset, asynchronous, active-low
- host_req_i  in  [NrHosts]  per-host request
- host_gnt_o  out  [NrHosts]  per-host grant
- host_addr_i  in  [NrHosts][AddrWidth]  address
- host_we_i  in  [NrHosts]  write enable
- host_be_i  in  [NrHosts][DataWidth/8]  byte enables
- host_wdata_i  in  [NrHosts][DataWidth]  write data
- host_rvalid_o  out  [NrHosts]  response valid
- host_rdata_o  out  [NrHosts][DataWidth]  read data, broadcast to all hosts
- host_err_o  out  [NrHosts]  response error
- dev_req_o  out  1  device request
- dev_gnt_i  in  1  device grant
- dev_addr_o  out  AddrWidth  muxed address
- dev_we_o  out  1  muxed write enable
- dev_be_o  out  DataWidth/8  muxed byte enables
- dev_wdata_o  out  DataWidth  muxed write data
- dev_rvalid_i  in  1  device response valid
- dev_rdata_i  in  DataWidth  device read data
- dev_err_i  in  1  device error
- spurious_rsp_o  out  1  sticky flag: response received with no outstanding transaction

Behaviour:
- Reset: all outputs 0, RR pointer = 0, FIFO empty, lock clear.
- Selection: among requesting hosts, choose the first at or after the RR pointer, wrapping modulo NrHosts.
  - dev_req_o = any host_req_i & !fifo_full.
  - dev_addr/we/be/wdata come combinationally from the selected host (zero-cycle request path).
- Accept: accept = dev_req_o & dev_gnt_i.
  - host_gnt_o[sel] = accept; all other grants are 0.
  - On accept, push sel into the FIFO and set RR pointer = sel+1 (wrapping).
- Stability lock:
  - If dev_req_o is high without dev_gnt_i, register lock = 1 and locked_id = sel.
  - While locked, selection is forced to locked_id, so no re-arbitration occurs mid-handshake.
  - Lock clears on accept, or if host_req_i[locked_id] drops (tolerated; release next cycle).
- Full: with fifo_full, dev_req_o = 0 and all grants are 0.
  - A pop in the same cycle does not unblock until the next cycle (registered count).
- Response routing:
  - On dev_rvalid_i with FIFO non-empty, host_rvalid_o[head] = 1 and host_err_o[head] = dev_err_i, combinationally.
  - host_rdata_o = dev_rdata_i to all hosts. Pop the FIFO.
- Simultaneous push and pop: both take effect, so the count is unchanged.
  - With the FIFO empty, a same-cycle accept and rvalid counts as spurious; zero-latency devices are not supported.
- Spurious response: dev_rvalid_i with the FIFO empty drives no host_rvalid and sets spurious_rsp_o.
  - spurious_rsp_o is sticky and is cleared only by reset.
- Single host requesting: it wins every cycle, with no idle bubbles between accepts.
- Reset mid-transaction: the FIFO and lock clear immediately. Responses in flight afterwards count as spurious.

Optional Feature:
- Macro: BUS_HOST_ARB_STATS_EN.
- With the macro defined:
  - Extra output port grant_cnt_o, [NrHosts][32]: per-host counters that increment on each accept for that host.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
  - Extra output port stall_cnt_o, 32 bits: counts cycles with any host_req_i & !accept, also saturating.
- Without the macro: these ports and counters do not exist, and the remaining behaviour is unchanged.

Decomposition:
- Package bus_arb_pkg holds:
  - the IdW function (clog2 wrapper);
  - typedef arb_state_t {ARB_IDLE, ARB_LOCKED};
  - the saturating-counter max constant.
- Sub-module arb_id_fifo (parameters Depth, Width):
  - synchronous push/pop, full/empty, registered count;
  - reset to empty;
  - instantiated once for the outstanding IDs.

Test Plan:
- Host0 and host1 both request continuously; device dev_gnt_i = 1 with rvalid 1 cycle later.
  - Required: grants alternate 0,1,0,1.
  - Required: each host receives rvalid exactly 1 cycle after its own grant, with rdata = 0xA5A5_0000 + ID.
- Device holds dev_gnt_i = 0 for 3 cycles while host0 is pending and host1 raises req in cycle 2.
  - Required: dev_addr_o stays at host0's address, and host0 is granted first.
- Device grants 4 requests and withholds rvalid (MaxOutstanding = 4).
  - Required: dev_req_o = 0 while full, and resumes the cycle after the first rvalid.
- Outstanding IDs 1,0,1; responses with err = 0,1,0.
  - Required: host_rvalid_o order is host1, host0 (err = 1), host1.
- dev_rvalid_i pulsed with the FIFO empty.
  - Required: no host_rvalid; spurious_rsp_o = 1, and it stays set until reset.
- rst_sys_ni asserted with 2 outstanding, then released.
  - Required: outputs are 0 during reset.
  - Required: after release, host0 is granted first (RR pointer = 0).
  - With BUS_HOST_ARB_STATS_EN: grant_cnt_o is 0 after reset and equals the number of accepts afterwards.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the bus host arbiter.
package bus_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    localparam logic [31:0] CntSatMax = 32'hFFFF_FFFF;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: synchronous FIFO of outstanding host IDs with a registered occupancy count.
module arb_id_fifo #(
    parameter int Depth = 4,
    parameter int Width = 1
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [PtrW:0]    cnt_q;
    logic             do_push, do_pop;

    assign full    = cnt_q == (PtrW + 1)'(Depth);
    assign empty   = cnt_q == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_q];

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= do_push ? wr_q + PtrW'(1) : wr_q;
            rd_q  <= do_pop ? rd_q + PtrW'(1) : rd_q;
            cnt_q <= cnt_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// bus_host_arbiter: round-robin arbitration of several bus hosts onto one device port, routing responses by ID.
// Optional per-host grant and stall counters are built with BUS_HOST_ARB_STATS_EN.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts        = 2,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                                clk_sys_i,
    input  logic                                rst_sys_ni,
    input  logic [NrHosts-1:0]                  host_req_i,
    output logic [NrHosts-1:0]                  host_gnt_o,
    input  logic [NrHosts-1:0][AddrWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                  host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0] host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]   host_wdata_i,
    output logic [NrHosts-1:0]                  host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]   host_rdata_o,
    output logic [NrHosts-1:0]                  host_err_o,
    output logic                                dev_req_o,
    input  logic                                dev_gnt_i,
    output logic [AddrWidth-1:0]                dev_addr_o,
    output logic                                dev_we_o,
    output logic [DataWidth/8-1:0]              dev_be_o,
    output logic [DataWidth-1:0]                dev_wdata_o,
    input  logic                                dev_rvalid_i,
    input  logic [DataWidth-1:0]                dev_rdata_i,
    input  logic                                dev_err_i,
    output logic                                spurious_rsp_o
`ifdef BUS_HOST_ARB_STATS_EN
    ,
    output logic [NrHosts-1:0][31:0]            grant_cnt_o,
    output logic [31:0]                         stall_cnt_o
`endif
);
    localparam int IdW = id_w(NrHosts);

    arb_state_t     state_q, state_d;
    logic [IdW-1:0] locked_id_q, locked_id_d, rr_q, rr_d, rr_sel, sel, head;
    logic           fifo_full, fifo_empty, any_req, dev_req, accept, rsp_ok, spurious_q;
    int             best;

    // Pick the requester with the smallest distance past the round-robin pointer.
    always_comb begin
        rr_sel = rr_q;
        best   = NrHosts;
        for (int h = 0; h < NrHosts; h++) begin
            if (host_req_i[h] && ((h - int'(rr_q) + NrHosts) % NrHosts) < best) begin
                best   = (h - int'(rr_q) + NrHosts) % NrHosts;
                rr_sel = IdW'(h);
            end
        end
    end

    assign sel     = (state_q == ARB_LOCKED && host_req_i[locked_id_q]) ? locked_id_q : rr_sel;
    assign any_req = |host_req_i;
    assign dev_req = any_req & ~fifo_full;
    assign accept  = dev_req & dev_gnt_i;
    assign rsp_ok  = dev_rvalid_i & ~fifo_empty;

    // Outputs are forced quiet while reset is held, even if hosts keep requesting.
    assign dev_req_o      = dev_req & rst_sys_ni;
    assign host_gnt_o     = (accept & rst_sys_ni) ? NrHosts'(1) << sel : '0;
    assign dev_addr_o     = rst_sys_ni ? host_addr_i[sel] : '0;
    assign dev_we_o       = rst_sys_ni & host_we_i[sel];
    assign dev_be_o       = rst_sys_ni ? host_be_i[sel] : '0;
    assign dev_wdata_o    = rst_sys_ni ? host_wdata_i[sel] : '0;
    assign host_rvalid_o  = rsp_ok ? NrHosts'(1) << head : '0;
    assign host_err_o     = (rsp_ok & dev_err_i) ? NrHosts'(1) << head : '0;
    assign host_rdata_o   = rst_sys_ni ? {NrHosts{dev_rdata_i}} : '0;
    assign spurious_rsp_o = spurious_q;

    always_comb begin
        rr_d        = accept ? ((sel == IdW'(NrHosts - 1)) ? '0 : sel + IdW'(1)) : rr_q;
        state_d     = (dev_req & ~dev_gnt_i) ? ARB_LOCKED : ARB_IDLE;
        locked_id_d = (dev_req & ~dev_gnt_i) ? sel : locked_id_q;
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q     <= ARB_IDLE;
            locked_id_q <= '0;
            rr_q        <= '0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            locked_id_q <= locked_id_d;
            rr_q        <= rr_d;
            spurious_q  <= spurious_q | (dev_rvalid_i & fifo_empty);
        end
    end

    arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk_sys_i  (clk_sys_i),
        .rst_sys_ni (rst_sys_ni),
        .push       (accept),
        .push_data  (sel),
        .pop        (dev_rvalid_i),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

`ifdef BUS_HOST_ARB_STATS_EN
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            grant_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            for (int h = 0; h < NrHosts; h++) begin
                if (accept && sel == IdW'(h) && grant_cnt_o[h] != CntSatMax)
                    grant_cnt_o[h] <= grant_cnt_o[h] + 32'd1;
            end
            if (any_req && !accept && stall_cnt_o != CntSatMax) stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
